// File: rtl/conv_out_writer_if.sv
// Stream-in / memory-out bundle for conv_out_writer.
// slave  : the writer (consumes the PE stream, drives the memory port).
// master : the environment (drives the PE stream, observes the memory port).
interface conv_out_writer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_wr_en,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/conv_out_writer.sv
// Writer side of the conv memory interface: requantizes 32-bit PE results to bytes and
// writes them linearly (channel-major, row-major planes) starting at a latched base address.
// Build option: define CONV_OUT_RELU_EN for ReLU + unsigned saturation; otherwise the
// requantizer saturates to a signed byte.
module conv_out_writer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned OUT_W  = 13,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  conv_out_writer_if.slave  bus
);

  localparam int unsigned TOTAL = NUM_CH * OUT_W * OUT_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              accept;

  // Arithmetic shift (floor), then saturate; the byte never wraps.
  function automatic logic [7:0] requant(input logic [31:0] x);
    logic signed [31:0] s;
    logic [7:0]         r;
    s = $signed(x) >>> SHIFT;
`ifdef CONV_OUT_RELU_EN
    if (s < 0) begin
      r = 8'h00;
    end else if (s > 32'sd255) begin
      r = 8'hFF;
    end else begin
      r = s[7:0];
    end
`else
    if (s < -32'sd128) begin
      r = 8'h80;
    end else if (s > 32'sd127) begin
      r = 8'h7F;
    end else begin
      r = s[7:0];
    end
`endif
    return r;
  endfunction

  // Next-state: FSM sequencing, word counting and the registered write port.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = bus.in_valid && (state_q == StRun);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          base_d  = base_addr;
          count_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          wr_en_d = 1'b1;
          // Address wraps modulo 2^ADDR_W by truncation.
          addr_d  = base_q + ADDR_W'(count_q);
          wdata_d = requant(bus.in_data);
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(TOTAL - 1)) begin
            state_d = StFlush;
          end
        end
      end
      // Final write is visible during FLUSH; DONE follows one cycle later.
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset wins over any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      base_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready  = (state_q == StRun);
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule
